// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// the FSM state type, the iteration count and the divide-by-zero quotient.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_t;

   localparam int          MD_ITER     = 32;
   localparam logic [31:0] MD_DIV0_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_seq.sv
// Sequential radix-2 multiply/divide unit producing {hi, lo} for the Lo/Hi registers.
// Magnitudes are processed for MD_ITER cycles; the sign correction is applied in FIX.
module mult_div_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_mult,
   input  logic               is_unsigned,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int W2 = 2 * WIDTH;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v, input logic neg);
      return neg ? (~v + W2'(1)) : v;
   endfunction

   md_state_t         state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              mult_q, mult_d;
   logic              uns_q, uns_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic              bzero_q, bzero_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [W2-1:0]     result_q, result_d;

   logic              accept;
   logic              last_step;
   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [WIDTH:0]    add_sum, rem_sh, diff;
   logic [W2-1:0]     step_acc, fix_res;
   logic [WIDTH-1:0]  fix_quo, fix_rem;
   logic              neg_p, neg_r;

   assign accept    = start && (state_q == IDLE || state_q == DONE);
   assign last_step = (cnt_q == 6'(MD_ITER - 1));

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM: next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (last_step) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = start ? CALC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs decoded straight from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         CALC, FIX: busy = 1'b1;
         DONE:      done = 1'b1;
         default:   ;
      endcase
   end

   // One radix-2 step: multiply shifts right through the accumulator,
   // divide shifts {rem, quo} left and keeps the trial subtraction if it fits.
   always_comb begin
      add_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh  = acc_q[W2-1:WIDTH-1];
      diff    = rem_sh - {1'b0, opb_q};
      if (mult_q) step_acc = {add_sum, acc_q[WIDTH-1:1]};
      else        step_acc = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                              acc_q[WIDTH-2:0], ~diff[WIDTH]};
   end

   // Sign correction; the remainder follows the dividend's sign.
   always_comb begin
      neg_p   = ~uns_q & (sa_q ^ sb_q);
      neg_r   = ~uns_q & sa_q;
      fix_quo = bzero_q ? WIDTH'(MD_DIV0_QUO) : neg_w(acc_q[WIDTH-1:0], neg_p);
      fix_rem = neg_w(acc_q[W2-1:WIDTH], neg_r);
      fix_res = mult_q ? neg_w2(acc_q, neg_p) : {fix_rem, fix_quo};
   end

   assign abs_a = neg_w(a, ~is_unsigned & a[WIDTH-1]);
   assign abs_b = neg_w(b, ~is_unsigned & b[WIDTH-1]);

   always_comb begin
      cnt_d    = cnt_q;
      mult_d   = mult_q;
      uns_d    = uns_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      bzero_d  = bzero_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (accept) begin
         cnt_d   = '0;
         mult_d  = is_mult;
         uns_d   = is_unsigned;
         sa_d    = a[WIDTH-1];
         sb_d    = b[WIDTH-1];
         bzero_d = (b == '0);
         opb_d   = is_mult ? abs_a : abs_b;
         acc_d   = {{WIDTH{1'b0}}, (is_mult ? abs_b : abs_a)};
      end else if (state_q == CALC) begin
         cnt_d = cnt_q + 6'd1;
         acc_d = step_acc;
      end else if (state_q == FIX) begin
         result_d = fix_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         mult_q   <= 1'b0;
         uns_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bzero_q  <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         mult_q   <= mult_d;
         uns_q    <= uns_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         bzero_q  <= bzero_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: reference model feeds an expected queue,
// results are popped and compared when done is seen.
module tb_mult_div_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        is_mult;
   logic        is_unsigned;
   logic        busy;
   logic        done;
   logic [63:0] result;

   logic [63:0] exp_q[$];
   logic [63:0] last_exp;
   int          n_checks;
   int          n_fails;

   mult_div_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .is_mult     (is_mult),
      .is_unsigned (is_unsigned),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic m, input logic u);
      longint sx, sy, q, r;
      sx = u ? longint'({32'b0, x}) : longint'($signed(x));
      sy = u ? longint'({32'b0, y}) : longint'($signed(y));
      if (m) return 64'(sx * sy);
      if (y == 32'b0) return {x, 32'hFFFF_FFFF};
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   // Called away from a clock edge; the next rising edge is the start edge.
   task automatic do_op(input logic [31:0] aa, input logic [31:0] bb,
                        input logic m, input logic u, input bit inject);
      int n;
      int busy_cnt;
      a           = aa;
      b           = bb;
      is_mult     = m;
      is_unsigned = u;
      start       = 1'b1;
      exp_q.push_back(model(aa, bb, m, u));
      @(posedge clk); #1;
      start    = 1'b0;
      n        = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && n < 40) begin
         if (inject && (n == 5 || n == 20)) begin
            start       = 1'b1;
            a           = $urandom;
            b           = $urandom;
            is_mult     = ~m;
            is_unsigned = ~u;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (busy) busy_cnt++;
      end
      start    = 1'b0;
      last_exp = exp_q.pop_front();
      if (done) begin
         check("latency", 64'(n), 64'd34);
         check("busy_cycles", 64'(busy_cnt), 64'd33);
         check("result", result, last_exp);
      end else begin
         check("done_timeout", 64'd0, 64'd1);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      rst         = 1'b1;
      start       = 1'b0;
      a           = '0;
      b           = '0;
      is_mult     = 1'b0;
      is_unsigned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op(32'hFFFF_FFFF, 32'd2,         1'b1, 1'b0, 1'b0); @(negedge clk);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0); @(negedge clk);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0); @(negedge clk);
      do_op(32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 1'b0); @(negedge clk);
      do_op(32'd100,       32'd7,         1'b0, 1'b1, 1'b0); @(negedge clk);
      do_op(32'h1234_5678, 32'd0,         1'b0, 1'b1, 1'b0); @(negedge clk);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); @(negedge clk);
      do_op(32'hFFFF_FFF9, 32'd0,         1'b0, 1'b0, 1'b0); @(negedge clk);

      // Starts pulsed mid-operation must be ignored.
      do_op(32'h0001_2345, 32'h0000_6789, 1'b1, 1'b1, 1'b1); @(negedge clk);
      do_op(32'hFFFF_1000, 32'h0000_0013, 1'b0, 1'b0, 1'b1); @(negedge clk);

      // Back-to-back: second start issued in the DONE cycle, then hold check.
      do_op(32'h0000_BEEF, 32'h0000_0101, 1'b1, 1'b1, 1'b0);
      do_op(32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("result_hold", result, last_exp);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         do_op($urandom, (i == 3) ? 32'd0 : 32'($urandom_range(0, 32'hFFFF_FFFF) >> (i * 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      a           = 32'h7777_1234;
      b           = 32'h0000_0321;
      is_mult     = 1'b1;
      is_unsigned = 1'b0;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(32'd3, 32'd5, 1'b1, 1'b1, 1'b0);
      check("post_rst_mult", result, 64'd15);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Sequential radix-2 multiply/divide unit for the MIPS core. It takes the `rs`/`rt` operands from the register file and produces the 64-bit `{hi, lo}` value that is written into the Lo/Hi register. It implements `mult`, `multu`, `div` and `divu` with a fixed 34-cycle latency and a start/busy/done handshake. The control unit stalls the PC while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the result is `2*WIDTH` bits.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request strobe; sampled only when not busy.
- `a`  in  WIDTH  operand A (`rs`); multiplicand or dividend.
- `b`  in  WIDTH  operand B (`rt`); multiplier or divisor.
- `is_mult`  in  1  1 = multiply, 0 = divide.
- `is_unsigned`  in  1  1 = unsigned, 0 = two's-complement signed.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle onward.
- `result`  out  2*WIDTH  `{hi, lo}`.
  - Multiply: full product.
  - Divide: `hi` = remainder, `lo` = quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE, `start`=1:
  - Latch `is_mult`, `is_unsigned`, the sign of `a`, the sign of `b`, and the absolute values of `a`/`b`. Absolute values are taken only when signed; unsigned operands are latched raw.
  - Clear the 6-bit iteration counter, then go to CALC.
- DONE with `start`=0: go to IDLE.
- CALC, one step per cycle, 32 cycles total:
  - Multiply: shift-add. If the accumulator LSB is 1, add the multiplicand to the upper half (33-bit add). Then shift right by 1.
  - Divide: restoring. Shift `{rem, quo}` left by 1 and trial-subtract the divisor from `rem` (33-bit). If the subtraction is non-negative, keep it and set the quotient LSB.
  - After the 32nd step, go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product if `sign(a)^sign(b)`.
  - Signed divide: negate the quotient if `sign(a)^sign(b)`; negate the remainder if `sign(a)`. The remainder takes the dividend's sign.
  - Register `result`, then go to DONE.
- Divide by zero (`b`==0), signed or unsigned: `lo`=0xFFFFFFFF, `hi`=`a` (original value). Latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. The natural magnitude datapath yields this; no special case is needed.
- `start` while busy is ignored. Operands are not re-sampled.
- Output values:
  - `busy` = (state==CALC || state==FIX).
  - `done` = (state==DONE).
  - `result` holds its value until the next FIX.

## Timing
- Reset, asserted at any time including mid-operation:
  - State goes to IDLE immediately (asynchronous).
  - `busy`=0, `done`=0, `result`=0, counter=0.
  - Any in-flight operation is discarded.
- `start` is sampled at edge E0. `busy` is high from E0 through E33 (33 cycles). `done` is high in the cycle after E33. Latency from the start edge to valid `result` is 34 clocks.
- Back-to-back: a `start` in the DONE cycle is accepted. There are no dead cycles between operations.
- Operands `a`/`b` only need to be valid in the `start` cycle.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Structure
- The shared package `mips_pkg` holds:
  - The state enum `md_state_t` (IDLE, CALC, FIX, DONE).
  - `MD_ITER` = 32.
  - Divide-by-zero constant `MD_DIV0_QUO` = 32'hFFFFFFFF.
- Single module, no sub-modules. An optional helper `md_negate` (conditional two's-complement, parameterised width) is used for both the operand absolute values and the FIX stage.

## Test plan
- Signed mult, `a`=0xFFFFFFFF, `b`=2 -> `result`=0xFFFFFFFF_FFFFFFFE. `done` arrives exactly 34 clocks after the start edge, and `busy` is high for 33 cycles.
- Unsigned mult, `a`=0xFFFFFFFF, `b`=0xFFFFFFFF -> `result`=0xFFFFFFFE_00000001. Signed mult of 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- Signed div, `a`=0xFFFFFFF9 (-7), `b`=2 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD. Unsigned div, 100 / 7 -> `hi`=2, `lo`=14.
- `divu` 0x12345678 / 0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF. Signed div 0x80000000 / 0xFFFFFFFF -> `hi`=0, `lo`=0x80000000.
- Handshake:
  - `start` pulsed at cycles +5 and +20 of a running operation, with new operands -> ignored; the result matches the first operands.
  - `start` in the DONE cycle -> a second result 34 clocks later.
- Assert `rst` at cycle 10 of an operation -> `busy`, `done` and `result` go to 0 without waiting for a clock edge. After `rst` is released, a fresh `mult` 3×5 -> `result`=15.
